// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter sharing one 8-bit text-LCD write bus between two requesters, with counter-timed rs/db setup, en pulse and hold.
// Optional power-up command sequence (38,0C,06,01) enabled by defining LCD_INIT_EN.
module lcd_bus_arbiter #(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PULSE_CYC = 4,
    parameter int unsigned HOLD_CYC  = 2,
    parameter int unsigned CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       busy,
    output logic       init_done,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_db,
    output logic       lcd_rst
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_gnt;
    logic             phase_end_c;
    logic             xfer0_c;
    logic             xfer1_c;
    logic             init_more_c;
    logic [7:0]       init_byte_c;

    assign lcd_rw      = 1'b0;
    assign phase_end_c = (cnt == '0);

`ifdef LCD_INIT_EN
    // init_idx points at the next ROM entry to issue; 4 means the sequence is finished
    logic [2:0] init_idx;

    always_comb begin
        init_more_c = (init_idx != 3'd4);
        case (init_idx[1:0])
            2'd0:    init_byte_c = 8'h38;
            2'd1:    init_byte_c = 8'h0C;
            2'd2:    init_byte_c = 8'h06;
            default: init_byte_c = 8'h01;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_idx <= '0;
        end else if (init_more_c && (state == IDLE || (state == HOLD && phase_end_c))) begin
            init_idx <= init_idx + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_done <= 1'b0;
        end else if (state == HOLD && phase_end_c && !init_more_c) begin
            init_done <= 1'b1;
        end
    end
`else
    assign init_more_c = 1'b0;
    assign init_byte_c = 8'h00;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
        end
    end
`endif

    // Grant: lone requester wins; on contention the port not granted last wins
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (rst_n && state == IDLE && init_done) begin
            if (req0_valid && req1_valid) begin
                req0_ready = last_gnt;
                req1_ready = !last_gnt;
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid && !req0_valid;
            end
        end
    end

    assign xfer0_c = req0_valid && req0_ready;
    assign xfer1_c = req1_valid && req1_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            last_gnt <= 1'b1;
            busy     <= 1'b0;
            lcd_en   <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_db   <= 8'h00;
            lcd_rst  <= 1'b0;
        end else begin
            lcd_rst <= 1'b1;
            case (state)
                IDLE: begin
                    if (init_more_c) begin
                        lcd_rs <= 1'b0;
                        lcd_db <= init_byte_c;
                        state  <= SETUP;
                        cnt    <= SETUP_LD;
                        busy   <= 1'b1;
                    end else if (xfer0_c) begin
                        lcd_rs   <= req0_rs;
                        lcd_db   <= req0_data;
                        last_gnt <= 1'b0;
                        state    <= SETUP;
                        cnt      <= SETUP_LD;
                        busy     <= 1'b1;
                    end else if (xfer1_c) begin
                        lcd_rs   <= req1_rs;
                        lcd_db   <= req1_data;
                        last_gnt <= 1'b1;
                        state    <= SETUP;
                        cnt      <= SETUP_LD;
                        busy     <= 1'b1;
                    end
                end
                SETUP: begin
                    if (phase_end_c) begin
                        state  <= PULSE;
                        cnt    <= PULSE_LD;
                        lcd_en <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                PULSE: begin
                    if (phase_end_c) begin
                        state  <= HOLD;
                        cnt    <= HOLD_LD;
                        lcd_en <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    // Init entries chain straight into the next SETUP with no IDLE gap
                    if (phase_end_c) begin
                        if (init_more_c) begin
                            lcd_rs <= 1'b0;
                            lcd_db <= init_byte_c;
                            state  <= SETUP;
                            cnt    <= SETUP_LD;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
